// File: rtl/spi_wb_xfer_ctrl_pkg.sv
// Register map and controller state encoding shared by the SPI Wishbone transfer controller.
// Register map: 0 SPCR, 1 SPSR, 2 SPDR, 3 SPER; SPIF is bit 7 of SPSR and is cleared by writing 1.
package spi_wb_pkg;

  localparam logic [2:0] ADR_SPCR = 3'd0;
  localparam logic [2:0] ADR_SPSR = 3'd1;
  localparam logic [2:0] ADR_SPDR = 3'd2;
  localparam logic [2:0] ADR_SPER = 3'd3;
  localparam int         SPIF_BIT = 7;
  localparam logic [7:0] SPIF_CLR = 8'h80;

  typedef enum logic [3:0] {
    ST_CFG_SPCR,
    ST_CFG_SPER,
    ST_IDLE,
    ST_WR_DR,
    ST_POLL_SR,
    ST_WAIT_IRQ,
    ST_RD_DR,
    ST_CLR_SF,
    ST_RESP
  } xfer_state_e;

endpackage

// File: rtl/spi_wb_xfer_ctrl_if.sv
// Byte request/response handshake plus the Wishbone link to the SPI core.
// The master modport is the controller's view; the slave modport is the environment's view.
interface spi_wb_xfer_ctrl_if;

  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic [2:0] wb_adr_o;
  logic       wb_we_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;
  logic       wb_inta_i;

  modport master (
    input  req_valid, req_data, wb_dat_i, wb_ack_i, wb_inta_i,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output wb_cyc_o, wb_stb_o, wb_adr_o, wb_we_o, wb_dat_o
  );

  modport slave (
    output req_valid, req_data, wb_dat_i, wb_ack_i, wb_inta_i,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_we_o, wb_dat_o
  );

endinterface

// File: rtl/spi_wb_xfer_ctrl_wbm.sv
// Single-access Wishbone engine: launches one cycle after start, completes on ack, gives up after ACK_TIMEOUT strobe cycles.
// Bus outputs are registered; a completed or aborted access is always followed by at least one idle cycle.
module wb_single_master #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] wdat_i,
  output logic       done_o,
  output logic       timeout_o,
  output logic [7:0] rdat_o,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [2:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i
);

  localparam int            CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [2:0]    adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic [CW-1:0] ack_cnt_q, ack_cnt_d;

  assign done_o    = stb_q && ack_i;
  assign timeout_o = stb_q && !ack_i && (ack_cnt_q == CNT_LAST);
  assign rdat_o    = dat_i;
  assign cyc_o     = stb_q;
  assign stb_o     = stb_q;
  assign we_o      = we_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;

  always_comb begin
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    ack_cnt_d = ack_cnt_q;
    // A launch is only possible while stb is low, which guarantees the idle gap after each access.
    if (!stb_q) begin
      if (start_i) begin
        stb_d     = 1'b1;
        we_d      = we_i;
        adr_d     = adr_i;
        dat_d     = we_i ? wdat_i : 8'h00;
        ack_cnt_d = '0;
      end
    end else if (done_o || timeout_o) begin
      stb_d     = 1'b0;
      we_d      = 1'b0;
      adr_d     = 3'd0;
      dat_d     = 8'h00;
      ack_cnt_d = '0;
    end else begin
      ack_cnt_d = ack_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 3'd0;
      dat_q     <= 8'h00;
      ack_cnt_q <= '0;
    end else begin
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

endmodule

// File: rtl/spi_wb_xfer_ctrl.sv
// Sequences the SPI core registers: one-time config, then per byte write SPDR, wait for SPIF, read SPDR, clear SPIF.
// req_ready only in IDLE; a zero-wait slave with SPIF on the first poll gives rsp_valid 9 cycles after accept.
module spi_wb_xfer_ctrl
  import spi_wb_pkg::*;
#(
  parameter logic [7:0] SPCR_VAL    = 8'h50,
  parameter logic [7:0] SPER_VAL    = 8'h00,
  parameter bit         USE_IRQ     = 1'b0,
  parameter int         ACK_TIMEOUT = 16,
  parameter int         POLL_MAX    = 1024
) (
  input logic               clk_i,
  input logic               rst_i,
  spi_wb_xfer_ctrl_if.master bus
);

  localparam int            PW       = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);

  xfer_state_e   state_q, state_d;
  logic          cfg_done_q, cfg_done_d;
  logic [7:0]    req_byte_q, req_byte_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          err_q, err_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [PW-1:0] poll_inc;

  logic       start, we, abort;
  logic [2:0] adr;
  logic [7:0] wdat;
  logic       done, timeout;
  logic [7:0] rdat;

  wb_single_master #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wbm (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start),
    .we_i     (we),
    .adr_i    (adr),
    .wdat_i   (wdat),
    .done_o   (done),
    .timeout_o(timeout),
    .rdat_o   (rdat),
    .cyc_o    (bus.wb_cyc_o),
    .stb_o    (bus.wb_stb_o),
    .we_o     (bus.wb_we_o),
    .adr_o    (bus.wb_adr_o),
    .dat_o    (bus.wb_dat_o),
    .dat_i    (bus.wb_dat_i),
    .ack_i    (bus.wb_ack_i)
  );

  assign poll_inc      = poll_cnt_q + PW'(1);
  assign bus.req_ready = (state_q == ST_IDLE) && cfg_done_q;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_err   = (state_q == ST_RESP) && err_q;
  assign bus.rsp_data  = rsp_data_q;

  always_comb begin
    state_d    = state_q;
    cfg_done_d = cfg_done_q;
    req_byte_d = req_byte_q;
    rx_d       = rx_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    poll_cnt_d = poll_cnt_q;
    start      = 1'b0;
    we         = 1'b0;
    adr        = ADR_SPCR;
    wdat       = 8'h00;
    abort      = 1'b0;

    case (state_q)
      ST_CFG_SPCR: begin
        start = 1'b1;
        we    = 1'b1;
        adr   = ADR_SPCR;
        wdat  = SPCR_VAL;
        if (done) state_d = ST_CFG_SPER;
      end
      ST_CFG_SPER: begin
        start = 1'b1;
        we    = 1'b1;
        adr   = ADR_SPER;
        wdat  = SPER_VAL;
        if (done) begin
          cfg_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (timeout) begin
          state_d = ST_CFG_SPCR;
        end
      end
      ST_IDLE: begin
        if (bus.req_valid && cfg_done_q) begin
          req_byte_d = bus.req_data;
          poll_cnt_d = '0;
          state_d    = ST_WR_DR;
        end
      end
      ST_WR_DR: begin
        start = 1'b1;
        we    = 1'b1;
        adr   = ADR_SPDR;
        wdat  = req_byte_q;
        if (done)         state_d = USE_IRQ ? ST_WAIT_IRQ : ST_POLL_SR;
        else if (timeout) abort   = 1'b1;
      end
      ST_POLL_SR: begin
        start = 1'b1;
        adr   = ADR_SPSR;
        if (done) begin
          poll_cnt_d = poll_inc;
          if (rdat[SPIF_BIT])          state_d = ST_RD_DR;
          else if (poll_inc == POLL_LIM) abort  = 1'b1;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      ST_WAIT_IRQ: begin
        if (bus.wb_inta_i) begin
          state_d = ST_RD_DR;
        end else begin
          poll_cnt_d = poll_inc;
          if (poll_inc == POLL_LIM) abort = 1'b1;
        end
      end
      ST_RD_DR: begin
        start = 1'b1;
        adr   = ADR_SPDR;
        if (done) begin
          rx_d    = rdat;
          state_d = ST_CLR_SF;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      ST_CLR_SF: begin
        start = 1'b1;
        we    = 1'b1;
        adr   = ADR_SPSR;
        wdat  = SPIF_CLR;
        if (done) begin
          // rsp_data only changes on entry to RESP so it holds between responses.
          rsp_data_d = rx_q;
          err_d      = 1'b0;
          state_d    = ST_RESP;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_CFG_SPCR;
    endcase

    if (abort) begin
      rsp_data_d = 8'h00;
      err_d      = 1'b1;
      state_d    = ST_RESP;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_CFG_SPCR;
      cfg_done_q <= 1'b0;
      req_byte_q <= 8'h00;
      rx_q       <= 8'h00;
      rsp_data_q <= 8'h00;
      err_q      <= 1'b0;
      poll_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cfg_done_q <= cfg_done_d;
      req_byte_q <= req_byte_d;
      rx_q       <= rx_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

endmodule
